alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Command sequencer sitting directly upstream of the 16-bit `alu` instance. It accepts single operation requests over a valid/ready handshake, latches the operands and drives the ALU's `a`/`b`/`op` inputs. Because the ALU output is registered, the block waits one cycle for `res`/`overflow` and returns them over a valid/ready response channel. It also owns a 16-bit accumulator, so multiply-accumulate runs as two chained ALU passes.

## Interface
Parameters:
- `W`, 16, datapath width; must match the ALU. Only 16 is supported.

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RST`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_cmd`  in  3  command code: 0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 CLRACC, 5 LDACC, 6–7 reserved.
- `req_a`, `req_b`  in  16  operands.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_res`  out  16  result.
- `rsp_ovf`  out  1  overflow flag.
- `acc`  out  16  current accumulator value.
- `alu_a`, `alu_b`  out  16  ALU operands.
- `alu_op`  out  2  ALU op: 00 add, 01 sub, 10 mul.
- `alu_res`  in  16  registered ALU result.
- `alu_ovf`  in  1  registered ALU overflow, which is bit 16 of the 17-bit result.

## Operation
- A request is accepted on any edge where `req_valid & req_ready`. On acceptance the block latches `req_cmd`, `req_a` and `req_b`.
- States: IDLE, EXEC1, CAPT1, EXEC2, CAPT2, DONE.
- ADD/SUB/MUL path: IDLE → EXEC1 → CAPT1 → DONE.
  - In EXEC1, drive `alu_a=a`, `alu_b=b`, and `alu_op` = 00/01/10 for ADD/SUB/MUL.
  - In CAPT1, load `rsp_res<=alu_res` and `rsp_ovf<=alu_ovf`.
- MAC path: IDLE → EXEC1 (MUL a,b) → CAPT1 → EXEC2 → CAPT2 → DONE.
  - CAPT1 latches the product into an internal register `prod` and latches its overflow into `ovf1`.
  - EXEC2 drives `alu_a=acc`, `alu_b=prod`, `alu_op=00`.
  - CAPT2 sets `acc<=alu_res`, `rsp_res<=alu_res` and `rsp_ovf<=ovf1|alu_ovf`.
- CLRACC: IDLE → DONE. Sets `acc<=0`, `rsp_res<=0`, `rsp_ovf<=0`.
- LDACC: IDLE → DONE. Sets `acc<=a`, `rsp_res<=a`, `rsp_ovf<=0`.
- Reserved codes 6–7: IDLE → DONE with `rsp_res=0`, `rsp_ovf=0`; `acc` is unchanged.
- Only MAC, CLRACC and LDACC modify `acc`.
- DONE: `rsp_valid=1`. `rsp_res` and `rsp_ovf` stay stable until `rsp_valid & rsp_ready`; the block then moves to IDLE on that edge.
- Outside EXEC1 and EXEC2, `alu_a`, `alu_b` and `alu_op` are driven to 0. These outputs are combinational from state and latched operands.
- Overflow rules follow the ALU's 17-bit semantics:
  - ADD: carry out.
  - SUB: borrow, i.e. bit 16 of the 17-bit difference.
  - MUL: bit 16 of the product only; higher product bits are discarded.

## Timing
- Acceptance edge defines cycle 0.
- ADD/SUB/MUL: `rsp_valid` first high in cycle 3.
- MAC: `rsp_valid` first high in cycle 5.
- CLRACC/LDACC/reserved: `rsp_valid` first high in cycle 1.
- `req_ready` is low from cycle 1 until the response handshake edge.
  - The earliest next acceptance is the cycle after the response handshake, i.e. one bubble.
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_res=0`, `rsp_ovf=0`, `acc=0`, `alu_*=0`.
- Reset asserted in any state aborts the operation:
  - All registers return to their reset values on that edge.
  - No response is produced for the aborted request.
- If `req_valid` is asserted while the block is not in IDLE, it is ignored. The request is held by upstream.

## Structure
- Package `alu_ctrl_pkg` holds:
  - command codes `CMD_ADD…CMD_LDACC`;
  - ALU op constants `ALU_ADD=2'b00`, `ALU_SUB=2'b01`, `ALU_MUL=2'b10`;
  - the state enum.
- The ALU is not instantiated inside this block. The top level instantiates `alu` as a sibling and connects it via the `alu_*` ports.
- No sub-module; this is a single FSM plus datapath registers.

## Test plan
- ADD a=0xFFFF, b=0x0001 → `rsp_res=0x0000`, `rsp_ovf=1`, `rsp_valid` in cycle 3.
- SUB a=0x0003, b=0x0005 → `rsp_res=0xFFFE`, `rsp_ovf=1`.
- MUL a=0x0100, b=0x0100 → `rsp_res=0x0000`, `rsp_ovf=1`.
- MUL a=0x0200, b=0x0100 → `rsp_res=0x0000`, `rsp_ovf=0`.
- LDACC a=0x0010, then MAC a=3, b=4 → `rsp_res=0x001C`, `acc=0x001C`, `rsp_ovf=0`, `rsp_valid` in cycle 5.
- MAC with acc=0xFFF0, a=b=0x0010 → product 0x0100, `rsp_res=0x00F0`, `rsp_ovf=1`.
- Backpressure: hold `rsp_ready=0` for 4 cycles after ADD 2+3 → `rsp_res=0x0005` stable, `req_ready=0` throughout. Then assert `rsp_ready` → IDLE on the next edge.
- Assert `RST` in cycle 3 of a MAC with prior acc=0x0010 → no response, `acc=0`, `req_ready=1` the next cycle, `alu_*=0`.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU command sequencer: command codes, ALU op
// encodings and FSM state encodings.
package alu_ctrl_pkg;

  localparam logic [2:0] CMD_ADD    = 3'd0;
  localparam logic [2:0] CMD_SUB    = 3'd1;
  localparam logic [2:0] CMD_MUL    = 3'd2;
  localparam logic [2:0] CMD_MAC    = 3'd3;
  localparam logic [2:0] CMD_CLRACC = 3'd4;
  localparam logic [2:0] CMD_LDACC  = 3'd5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_EXEC1 = 3'd1;
  localparam state_t ST_CAPT1 = 3'd2;
  localparam state_t ST_EXEC2 = 3'd3;
  localparam state_t ST_CAPT2 = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/alu_ctrl.sv
// Command sequencer in front of a registered 16-bit ALU: runs single-pass
// ADD/SUB/MUL, a two-pass multiply-accumulate, and accumulator load/clear.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_cmd,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_ovf,
  output logic [W-1:0] acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_ovf
);

  state_t       state;
  logic [2:0]   cmd_r;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] prod;
  logic         ovf1;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  // The ALU is only driven while a pass is executing; MAC's first pass is a multiply.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (state == ST_EXEC1) begin
      alu_a = a_r;
      alu_b = b_r;
      case (cmd_r)
        CMD_SUB: alu_op = ALU_SUB;
        CMD_MUL: alu_op = ALU_MUL;
        CMD_MAC: alu_op = ALU_MUL;
        default: alu_op = ALU_ADD;
      endcase
    end else if (state == ST_EXEC2) begin
      alu_a  = acc;
      alu_b  = prod;
      alu_op = ALU_ADD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cmd_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      prod    <= '0;
      ovf1    <= 1'b0;
      acc     <= '0;
      rsp_res <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd_r <= req_cmd;
            a_r   <= req_a;
            b_r   <= req_b;
            case (req_cmd)
              CMD_ADD, CMD_SUB, CMD_MUL, CMD_MAC: state <= ST_EXEC1;
              CMD_CLRACC: begin
                acc     <= '0;
                rsp_res <= '0;
                rsp_ovf <= 1'b0;
                state   <= ST_DONE;
              end
              CMD_LDACC: begin
                acc     <= req_a;
                rsp_res <= req_a;
                rsp_ovf <= 1'b0;
                state   <= ST_DONE;
              end
              default: begin
                rsp_res <= '0;
                rsp_ovf <= 1'b0;
                state   <= ST_DONE;
              end
            endcase
          end
        end
        ST_EXEC1: state <= ST_CAPT1;
        // The ALU result registered at the end of EXEC1 is visible here.
        ST_CAPT1: begin
          if (cmd_r == CMD_MAC) begin
            prod  <= alu_res;
            ovf1  <= alu_ovf;
            state <= ST_EXEC2;
          end else begin
            rsp_res <= alu_res;
            rsp_ovf <= alu_ovf;
            state   <= ST_DONE;
          end
        end
        ST_EXEC2: state <= ST_CAPT2;
        ST_CAPT2: begin
          acc     <= alu_res;
          rsp_res <= alu_res;
          rsp_ovf <= ovf1 | alu_ovf;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a registered ALU stand-in, directed cases
// and randomized operations checked against an arithmetic reference model.
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_res;
  logic        rsp_ovf;
  logic [15:0] acc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_res;
  logic        alu_ovf;

  int checks;
  int errors;
  logic [15:0] acc_m;

  alu_ctrl #(.W(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_ovf(rsp_ovf), .acc(acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_ovf(alu_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered 17-bit ALU stand-in sitting beside the sequencer.
  logic [31:0] mul_full;
  logic [16:0] alu_next;
  assign mul_full = alu_a * alu_b;
  always_comb begin
    alu_next = '0;
    case (alu_op)
      2'b00: alu_next = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: alu_next = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: alu_next = mul_full[16:0];
      default: alu_next = '0;
    endcase
  end
  always @(posedge CLK) begin
    if (RST) {alu_ovf, alu_res} <= '0;
    else     {alu_ovf, alu_res} <= alu_next;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, checks latency, result and accumulator, holds the
  // response for 'hold' cycles, then completes the handshake.
  task automatic applyStimulus(input logic [2:0] cmd, input logic [15:0] a,
                               input logic [15:0] b, input int hold);
    logic [31:0] p;
    logic [16:0] full;
    logic [15:0] exp_res;
    logic        exp_ovf;
    logic [1:0]  exp_op;
    logic        computes;
    int          lat;
    int          n;
    exp_res  = '0;
    exp_ovf  = 1'b0;
    exp_op   = 2'b00;
    computes = 1'b1;
    lat      = 3;
    p        = a * b;
    case (cmd)
      3'd0: begin full = {1'b0, a} + {1'b0, b}; {exp_ovf, exp_res} = full; end
      3'd1: begin full = {1'b0, a} - {1'b0, b}; {exp_ovf, exp_res} = full; exp_op = 2'b01; end
      3'd2: begin {exp_ovf, exp_res} = p[16:0]; exp_op = 2'b10; end
      3'd3: begin
        full    = {1'b0, acc_m} + {1'b0, p[15:0]};
        exp_res = full[15:0];
        exp_ovf = p[16] | full[16];
        acc_m   = full[15:0];
        exp_op  = 2'b10;
        lat     = 5;
      end
      3'd4: begin acc_m = '0; computes = 1'b0; lat = 1; end
      3'd5: begin acc_m = a; exp_res = a; computes = 1'b0; lat = 1; end
      default: begin computes = 1'b0; lat = 1; end
    endcase

    @(negedge CLK);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    checkOutput("req_ready_before", {31'b0, req_ready}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      checkOutput("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (n == 1 && computes) begin
        checkOutput("alu_a_exec1", {16'b0, alu_a}, {16'b0, a});
        checkOutput("alu_b_exec1", {16'b0, alu_b}, {16'b0, b});
        checkOutput("alu_op_exec1", {30'b0, alu_op}, {30'b0, exp_op});
      end
      @(negedge CLK);
      n++;
    end
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", 32'd0, 32'd1);
      $fatal(1, "[TB] FAIL rsp_timeout: no response within 20 cycles");
    end
    checkOutput("latency", n, lat);
    checkOutput("rsp_res", {16'b0, rsp_res}, {16'b0, exp_res});
    checkOutput("rsp_ovf", {31'b0, rsp_ovf}, {31'b0, exp_ovf});
    checkOutput("acc", {16'b0, acc}, {16'b0, acc_m});
    checkOutput("alu_a_done", {16'b0, alu_a}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("hold_res", {16'b0, rsp_res}, {16'b0, exp_res});
      checkOutput("hold_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    checkOutput("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    acc_m     = '0;
    RST       = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_res", {16'b0, rsp_res}, 32'd0);
    checkOutput("rst_rsp_ovf", {31'b0, rsp_ovf}, 32'd0);
    checkOutput("rst_acc", {16'b0, acc}, 32'd0);
    checkOutput("rst_alu", {14'b0, alu_a, alu_op}, 32'd0);
    RST = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(CMD_ADD, 16'hFFFF, 16'h0001, 0);
    applyStimulus(CMD_SUB, 16'h0003, 16'h0005, 0);
    applyStimulus(CMD_MUL, 16'h0100, 16'h0100, 0);
    applyStimulus(CMD_MUL, 16'h0200, 16'h0100, 0);
    applyStimulus(CMD_LDACC, 16'h0010, 16'h0000, 0);
    applyStimulus(CMD_MAC, 16'h0003, 16'h0004, 0);
    applyStimulus(CMD_LDACC, 16'hFFF0, 16'h1234, 0);
    applyStimulus(CMD_MAC, 16'h0010, 16'h0010, 0);
    applyStimulus(CMD_CLRACC, 16'hABCD, 16'h0000, 0);
    applyStimulus(3'd6, 16'h1111, 16'h2222, 1);
    applyStimulus(CMD_ADD, 16'h0002, 16'h0003, 4);

    $display("[TB] reset during MAC");
    applyStimulus(CMD_LDACC, 16'h0010, 16'h0000, 0);
    @(negedge CLK);
    req_valid = 1'b1;
    req_cmd   = CMD_MAC;
    req_a     = 16'h0003;
    req_b     = 16'h0004;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST   = 1'b0;
    acc_m = '0;
    checkOutput("abort_acc", {16'b0, acc}, 32'd0);
    checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abort_alu", {alu_a, alu_b}, 32'd0);
    checkOutput("abort_alu_op", {30'b0, alu_op}, 32'd0);
    repeat (5) @(negedge CLK);
    checkOutput("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  c;
      logic [15:0] ra;
      logic [15:0] rb;
      c  = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 3));
      applyStimulus(c, ra, rb, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
